// File: rtl/gpu_bg_block_mover_pkg.sv
// gpu_bg_pkg: shared types and constants for the BG block mover.
// Holds the pair codes sent by the backend, the mover state enum and the
// block/mask/address widths. It also provides a helper that turns a block
// address into a VRAM byte address.
package gpu_bg_pkg;

  localparam int BG_BLOCK_W = 256;  // 16 pixels x 16 bits
  localparam int BG_MASK_W  = 16;   // one write-enable bit per pixel
  localparam int BG_ADR_W   = 15;   // {scrY[8:0], scrX[9:4]}
  localparam int BEATS      = 8;    // 32-bit beats per block
  localparam int BEAT_W     = 32;

  localparam logic [1:0] PAIR_NONE  = 2'b00;
  localparam logic [1:0] PAIR_FIRST = 2'b01;
  localparam logic [1:0] PAIR_NEXT  = 2'b10;
  localparam logic [1:0] PAIR_FLUSH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CMD  = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_LD_CMD  = 3'd3,
    ST_LD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // A block is 32 bytes, so the byte address is the block address shifted by 5.
  function automatic logic [BG_ADR_W+4:0] blk_byte_adr(input logic [BG_ADR_W-1:0] adr);
    return {adr, 5'b0};
  endfunction

endpackage

// File: rtl/gpu_bg_block_mover_if.sv
// gpu_bg_block_mover_if: VRAM command / write-beat / read-beat bus.
// master = block mover, slave = memory.
//   o_memReq/o_memWrite/o_memAdr  command (held until i_memAck)
//   o_memWValid/o_memWData/o_memWBE + i_memWReady  write beats
//   i_memRValid/i_memRData  read beats (no back-pressure)
interface gpu_bg_block_mover_if #(
  parameter int ADR_W = 20
);
  logic             o_memReq;
  logic             o_memWrite;
  logic [ADR_W-1:0] o_memAdr;
  logic             i_memAck;
  logic             o_memWValid;
  logic [31:0]      o_memWData;
  logic [3:0]       o_memWBE;
  logic             i_memWReady;
  logic             i_memRValid;
  logic [31:0]      i_memRData;

  modport master (
    output o_memReq, o_memWrite, o_memAdr, o_memWValid, o_memWData, o_memWBE,
    input  i_memAck, i_memWReady, i_memRValid, i_memRData
  );

  modport slave (
    input  o_memReq, o_memWrite, o_memAdr, o_memWValid, o_memWData, o_memWBE,
    output i_memAck, i_memWReady, i_memRValid, i_memRData
  );
endinterface

// File: rtl/gpu_bg_block_mover_beat_pack.sv
// gpu_bg_beat_pack: combinational slicing of a 256-bit block into the k-th
// 32-bit write beat, plus its byte enables.
// Ports: i_block (256), i_mask (16 per-pixel), i_beat (k, 0..7)
//        -> o_data (32), o_be (4)
// Every beat carries two 16-bit pixels. Each pixel's mask bit therefore
// drives the two byte enables of that pixel.
module gpu_bg_beat_pack
  import gpu_bg_pkg::*;
(
  input  logic [BG_BLOCK_W-1:0] i_block,
  input  logic [BG_MASK_W-1:0]  i_mask,
  input  logic [2:0]            i_beat,
  output logic [BEAT_W-1:0]     o_data,
  output logic [3:0]            o_be
);
  logic [BEAT_W-1:0] w_data [BEATS];
  logic [3:0]        w_be   [BEATS];

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      assign w_data[gi] = i_block[BEAT_W*gi +: BEAT_W];
      assign w_be[gi]   = {{2{i_mask[2*gi+1]}}, {2{i_mask[2*gi]}}};
    end
  endgenerate

  assign o_data = w_data[i_beat];
  assign o_be   = w_be[i_beat];
endmodule

// File: rtl/gpu_bg_block_mover.sv
// gpu_bg_block_mover: memory-side partner of the GPU backend's BG block cache.
// When the backend sends a pair code, the mover may write the dirty block to
// VRAM as masked beats. It may then read the next block and hand it back in a
// single-cycle import pulse.
// Ports: clk, i_nrst (async, active low); backend side i_saveBGBlock,
//   i_loadAdr, i_saveAdr, i_exportedBGBlock, i_exportedMSKBGBlock, o_busy,
//   o_importBGBlockSingleClock, o_importedBGBlock, o_resetPixelMask,
//   o_resetPipelinePixelStateSpike; memory side via mem (master modport).
// Optional: GPU_BGMOVER_PERF_EN adds saturating counters o_perfSaveCnt,
//   o_perfLoadCnt and o_perfSkipCnt.
module gpu_bg_block_mover
  import gpu_bg_pkg::*;
#(
  parameter int ADR_W = 20
) (
  input  logic                  clk,
  input  logic                  i_nrst,
  input  logic [1:0]            i_saveBGBlock,
  input  logic [BG_ADR_W-1:0]   i_loadAdr,
  input  logic [BG_ADR_W-1:0]   i_saveAdr,
  input  logic [BG_BLOCK_W-1:0] i_exportedBGBlock,
  input  logic [BG_MASK_W-1:0]  i_exportedMSKBGBlock,
  output logic                  o_busy,
  output logic                  o_importBGBlockSingleClock,
  output logic [BG_BLOCK_W-1:0] o_importedBGBlock,
  output logic                  o_resetPixelMask,
  output logic                  o_resetPipelinePixelStateSpike,
  gpu_bg_block_mover_if.master  mem
`ifdef GPU_BGMOVER_PERF_EN
  ,
  output logic [15:0]           o_perfSaveCnt,
  output logic [15:0]           o_perfLoadCnt,
  output logic [15:0]           o_perfSkipCnt
`endif
);
  state_t                r_state;
  state_t                w_state_next;
  logic                  r_armed;
  logic                  r_load;       // snapshotted code includes a load
  logic [BG_ADR_W-1:0]   r_load_adr;
  logic [BG_ADR_W-1:0]   r_save_adr;
  logic [BG_BLOCK_W-1:0] r_block;
  logic [BG_MASK_W-1:0]  r_mask;
  logic [2:0]            r_beat;
  logic                  r_rpm;
  logic [BG_BLOCK_W-1:0] r_imported;

  logic                  w_accept;
  logic                  w_has_load;
  logic                  w_save_run;
  logic                  w_wfire;
  logic                  w_rfire;
  logic                  w_last;
  logic [BEAT_W-1:0]     w_pack_data;
  logic [3:0]            w_pack_be;

  gpu_bg_beat_pack u_pack (
    .i_block (r_block),
    .i_mask  (r_mask),
    .i_beat  (r_beat),
    .o_data  (w_pack_data),
    .o_be    (w_pack_be)
  );

  assign w_accept   = (r_state == ST_IDLE) && r_armed && (i_saveBGBlock != PAIR_NONE);
  assign w_has_load = (i_saveBGBlock == PAIR_FIRST) || (i_saveBGBlock == PAIR_NEXT);
  // A save with an all-zero mask would write nothing, so it is skipped.
  assign w_save_run = ((i_saveBGBlock == PAIR_NEXT) || (i_saveBGBlock == PAIR_FLUSH)) &&
                      (i_exportedMSKBGBlock != '0);
  assign w_wfire    = (r_state == ST_WR_DATA) && mem.i_memWReady;
  assign w_rfire    = (r_state == ST_LD_DATA) && mem.i_memRValid;
  assign w_last     = (r_beat == 3'(BEATS - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_save_run)      w_state_next = ST_WR_CMD;
          else if (w_has_load) w_state_next = ST_LD_CMD;
          else                 w_state_next = ST_DONE;
        end
      end
      ST_WR_CMD:  if (mem.i_memAck) w_state_next = ST_WR_DATA;
      ST_WR_DATA: if (w_wfire && w_last) w_state_next = r_load ? ST_LD_CMD : ST_DONE;
      ST_LD_CMD:  if (mem.i_memAck) w_state_next = ST_LD_DATA;
      ST_LD_DATA: if (w_rfire && w_last) w_state_next = ST_DONE;
      ST_DONE:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // All outputs decode from state, so an asynchronous reset clears them at once.
  always_comb begin
    mem.o_memReq   = (r_state == ST_WR_CMD) || (r_state == ST_LD_CMD);
    mem.o_memWrite = (r_state == ST_WR_CMD);
    mem.o_memAdr   = '0;
    if (r_state == ST_WR_CMD) mem.o_memAdr = ADR_W'(blk_byte_adr(r_save_adr));
    if (r_state == ST_LD_CMD) mem.o_memAdr = ADR_W'(blk_byte_adr(r_load_adr));
    mem.o_memWValid = (r_state == ST_WR_DATA);
    mem.o_memWData  = (r_state == ST_WR_DATA) ? w_pack_data : '0;
    mem.o_memWBE    = (r_state == ST_WR_DATA) ? w_pack_be : '0;
  end

  assign o_busy                         = (r_state != ST_IDLE);
  assign o_importBGBlockSingleClock     = (r_state == ST_DONE) && r_load;
  assign o_resetPipelinePixelStateSpike = (r_state == ST_DONE);
  assign o_resetPixelMask               = r_rpm;
  assign o_importedBGBlock              = r_imported;

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b1;
      r_load     <= 1'b0;
      r_load_adr <= '0;
      r_save_adr <= '0;
      r_block    <= '0;
      r_mask     <= '0;
      r_beat     <= '0;
      r_rpm      <= 1'b0;
      r_imported <= '0;
    end else begin
      r_state <= w_state_next;
      r_rpm   <= 1'b0;
      // Re-arm only after the backend has dropped the code to none.
      if (i_saveBGBlock == PAIR_NONE) r_armed <= 1'b1;
      if (w_accept) begin
        r_armed    <= 1'b0;
        r_load     <= w_has_load;
        r_load_adr <= i_loadAdr;
        r_save_adr <= i_saveAdr;
        r_block    <= i_exportedBGBlock;
        r_mask     <= i_exportedMSKBGBlock;
        r_beat     <= '0;
        // No save will run (load-only or empty mask): release the mask now.
        r_rpm      <= !w_save_run;
      end
      if (w_wfire) begin
        r_beat <= r_beat + 3'd1;
        if (w_last) r_rpm <= 1'b1;
      end
      if (w_rfire) begin
        r_imported[{r_beat, 5'b0} +: BEAT_W] <= mem.i_memRData;
        r_beat <= r_beat + 3'd1;
      end
    end
  end

`ifdef GPU_BGMOVER_PERF_EN
  logic [15:0] r_perf_save;
  logic [15:0] r_perf_load;
  logic [15:0] r_perf_skip;

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_perf_save <= '0;
      r_perf_load <= '0;
      r_perf_skip <= '0;
    end else begin
      if (w_wfire && w_last && (r_perf_save != 16'hFFFF)) r_perf_save <= r_perf_save + 16'd1;
      if (w_rfire && w_last && (r_perf_load != 16'hFFFF)) r_perf_load <= r_perf_load + 16'd1;
      if (w_accept && (i_saveBGBlock != PAIR_FIRST) && !w_save_run &&
          (r_perf_skip != 16'hFFFF))
        r_perf_skip <= r_perf_skip + 16'd1;
    end
  end

  assign o_perfSaveCnt = r_perf_save;
  assign o_perfLoadCnt = r_perf_load;
  assign o_perfSkipCnt = r_perf_skip;
`endif

endmodule

// File: tb/tb_gpu_bg_block_mover.sv
module tb_gpu_bg_block_mover;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         i_nrst;
  logic [1:0]   code;
  logic [14:0]  ladr;
  logic [14:0]  sadr;
  logic [255:0] blk;
  logic [15:0]  msk;
  logic         busy;
  logic         imp;
  logic [255:0] imported;
  logic         rpm;
  logic         spike;
  logic         spur_ack = 1'b0;
  logic         rvalid = 1'b0;
  logic [31:0]  rdata = '0;
  logic [31:0]  rd_beats [8];
`ifdef GPU_BGMOVER_PERF_EN
  logic [15:0]  perf_save;
  logic [15:0]  perf_load;
  logic [15:0]  perf_skip;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_wcmd = 0;
  int n_rcmd = 0;
  int n_wbeats = 0;
  int n_imp = 0;
  int n_rpm = 0;
  int n_spike = 0;
  logic [3:0] seen_be [8];

  logic [20:0]  exp_cmd_q  [$];  // {write, byte address}
  logic [35:0]  exp_beat_q [$];  // {data, byte enables}
  logic [255:0] exp_imp_q  [$];

  gpu_bg_block_mover_if #(.ADR_W(20)) mem_if ();
  assign mem_if.i_memAck    = mem_if.o_memReq | spur_ack;
  assign mem_if.i_memWReady = 1'b1;
  assign mem_if.i_memRValid = rvalid;
  assign mem_if.i_memRData  = rdata;

  gpu_bg_block_mover #(.ADR_W(20)) dut (
    .clk                            (clk),
    .i_nrst                         (i_nrst),
    .i_saveBGBlock                  (code),
    .i_loadAdr                      (ladr),
    .i_saveAdr                      (sadr),
    .i_exportedBGBlock              (blk),
    .i_exportedMSKBGBlock           (msk),
    .o_busy                         (busy),
    .o_importBGBlockSingleClock     (imp),
    .o_importedBGBlock              (imported),
    .o_resetPixelMask               (rpm),
    .o_resetPipelinePixelStateSpike (spike),
    .mem                            (mem_if)
`ifdef GPU_BGMOVER_PERF_EN
    ,
    .o_perfSaveCnt                  (perf_save),
    .o_perfLoadCnt                  (perf_load),
    .o_perfSkipCnt                  (perf_skip)
`endif
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Memory responder: a read command is followed by eight back-to-back read beats.
  initial begin
    forever begin
      @(negedge clk);
      if (i_nrst && mem_if.o_memReq && !mem_if.o_memWrite && mem_if.i_memAck) begin
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
          #1 rvalid = 1'b1;
          rdata = rd_beats[k];
          @(posedge clk);
        end
        #1 rvalid = 1'b0;
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (i_nrst) begin
      if (mem_if.o_memReq && mem_if.i_memAck) begin
        if (mem_if.o_memWrite) n_wcmd++; else n_rcmd++;
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", {mem_if.o_memWrite, mem_if.o_memAdr}, 21'h0);
        else check("cmd", {mem_if.o_memWrite, mem_if.o_memAdr}, exp_cmd_q.pop_front());
      end
      if (mem_if.o_memWValid && mem_if.i_memWReady) begin
        seen_be[n_wbeats % 8] = mem_if.o_memWBE;
        n_wbeats++;
        if (exp_beat_q.size() == 0) check("wbeat_unexpected", {mem_if.o_memWData, mem_if.o_memWBE}, 36'h0);
        else check("wbeat", {mem_if.o_memWData, mem_if.o_memWBE}, exp_beat_q.pop_front());
      end
      if (imp) begin
        n_imp++;
        if (exp_imp_q.size() == 0) check("import_unexpected", imported, 256'h0);
        else check("import", imported, exp_imp_q.pop_front());
      end
      if (rpm) n_rpm++;
      if (spike) n_spike++;
    end
  end

  // Drive one operation, push its expectations and measure accept->idle cycles.
  task automatic run_op(input logic [1:0] c, input logic [14:0] la, input logic [14:0] sa,
                        input logic [255:0] b, input logic [15:0] m, input int hold,
                        output int lat);
    logic do_save;
    logic do_load;
    logic [255:0] ib;
    do_save = ((c == 2'b10) || (c == 2'b11)) && (m != 16'h0);
    do_load = (c == 2'b01) || (c == 2'b10);
    if (do_save) begin
      exp_cmd_q.push_back({1'b1, sa, 5'b0});
      for (int k = 0; k < 8; k++)
        exp_beat_q.push_back({b[32*k +: 32], {2{m[2*k+1]}}, {2{m[2*k]}}});
    end
    if (do_load) begin
      exp_cmd_q.push_back({1'b0, la, 5'b0});
      for (int k = 0; k < 8; k++) ib[32*k +: 32] = rd_beats[k];
      exp_imp_q.push_back(ib);
    end
    @(posedge clk);
    #1 code = c; ladr = la; sadr = sa; blk = b; msk = m;
    @(posedge clk);
    #1 lat = 1;
    while (busy && lat < 300) begin
      @(posedge clk);
      #1 lat++;
    end
    if (lat >= 300) check("busy_timeout", 256'(lat), 256'd0);
    repeat (hold) @(posedge clk);
    #1 code = 2'b00;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 256'(busy), 256'd0);
    check({tag, "_imp"}, 256'(imp), 256'd0);
    check({tag, "_imported"}, imported, 256'd0);
    check({tag, "_rpm"}, 256'(rpm), 256'd0);
    check({tag, "_spike"}, 256'(spike), 256'd0);
    check({tag, "_req"}, 256'(mem_if.o_memReq), 256'd0);
    check({tag, "_wr"}, 256'(mem_if.o_memWrite), 256'd0);
    check({tag, "_adr"}, 256'(mem_if.o_memAdr), 256'd0);
    check({tag, "_wvalid"}, 256'(mem_if.o_memWValid), 256'd0);
    check({tag, "_wdata"}, 256'(mem_if.o_memWData), 256'd0);
    check({tag, "_wbe"}, 256'(mem_if.o_memWBE), 256'd0);
  endtask

  initial begin
    int lat;
    int rpm0;
    int imp0;
    int wc0;
    int rc0;
    logic [3:0] be_tab [8];
    logic [255:0] rnd_blk;
    be_tab = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h3, 4'h3, 4'hC, 4'hC};
    i_nrst = 1'b0; code = 2'b00; ladr = '0; sadr = '0; blk = '0; msk = '0;
    for (int k = 0; k < 8; k++) rd_beats[k] = 32'h11111111 * (k + 1);
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    i_nrst = 1'b1;
    repeat (2) @(posedge clk);

    // Spurious acknowledge while idle must not start anything.
    #1 spur_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("spur_ack_req", 256'(mem_if.o_memReq), 256'd0);
    check("spur_ack_busy", 256'(busy), 256'd0);
    spur_ack = 1'b0;

    // Op 01: load only.
    rpm0 = n_rpm; imp0 = n_imp; wc0 = n_wcmd; rc0 = n_rcmd;
    exp_cmd_q.push_back({1'b0, 20'h02460});
    rd_beats[0] = 32'h11111111;
    run_op(2'b01, 15'h0123, 15'h0055, 256'h0, 16'hFFFF, 3, lat);
    void'(exp_cmd_q.pop_back());  // literal address already queued ahead of the computed one
    check("op01_lo", 256'(imported[31:0]), 256'h11111111);
    check("op01_hi", 256'(imported[255:224]), 256'h88888888);
    check("op01_imp_cnt", 256'(n_imp - imp0), 256'd1);
    check("op01_rpm_cnt", 256'(n_rpm - rpm0), 256'd1);
    check("op01_wcmd_cnt", 256'(n_wcmd - wc0), 256'd0);
    check("op01_rcmd_cnt", 256'(n_rcmd - rc0), 256'd1);

    // Op 10 with mixed mask, zero-wait memory.
    for (int k = 0; k < 8; k++) rd_beats[k] = $urandom;
    for (int k = 0; k < 8; k++) rnd_blk[32*k +: 32] = $urandom;
    rpm0 = n_rpm; imp0 = n_imp; wc0 = n_wcmd; rc0 = n_rcmd;
    run_op(2'b10, 15'h0200, 15'h0040, rnd_blk, 16'hA5F0, 0, lat);
    check("op10_latency", 256'(lat), 256'd20);
    for (int k = 0; k < 8; k++) check($sformatf("op10_be%0d", k), 256'(seen_be[k]), 256'(be_tab[k]));
    check("op10_wcmd_cnt", 256'(n_wcmd - wc0), 256'd1);
    check("op10_rcmd_cnt", 256'(n_rcmd - rc0), 256'd1);
    check("op10_imp_cnt", 256'(n_imp - imp0), 256'd1);
    check("op10_rpm_cnt", 256'(n_rpm - rpm0), 256'd1);

    // Op 10 with empty mask: save skipped, load still runs.
    for (int k = 0; k < 8; k++) rd_beats[k] = $urandom;
    rpm0 = n_rpm; imp0 = n_imp; wc0 = n_wcmd;
    run_op(2'b10, 15'h7FFF, 15'h1234, rnd_blk, 16'h0000, 0, lat);
    check("skip_wcmd_cnt", 256'(n_wcmd - wc0), 256'd0);
    check("skip_rpm_cnt", 256'(n_rpm - rpm0), 256'd1);
    check("skip_imp_cnt", 256'(n_imp - imp0), 256'd1);

    // Op 11 held for 100 cycles, dropped, then issued again.
    imp0 = n_imp; wc0 = n_wcmd;
    run_op(2'b11, 15'h0001, 15'h0ABC, ~rnd_blk, 16'hFFFF, 100, lat);
    run_op(2'b11, 15'h0001, 15'h0ABD, rnd_blk, 16'h8001, 0, lat);
    check("flush_wcmd_cnt", 256'(n_wcmd - wc0), 256'd2);
    check("flush_imp_cnt", 256'(n_imp - imp0), 256'd0);

    // Reset during write beat 3.
    rpm0 = n_rpm; wc0 = n_wbeats;
    exp_cmd_q.push_back({1'b1, 15'h0066, 5'b0});
    for (int k = 0; k < 3; k++) exp_beat_q.push_back({rnd_blk[32*k +: 32], 4'hF});
    @(posedge clk);
    #1 code = 2'b10; sadr = 15'h0066; ladr = 15'h0077; blk = rnd_blk; msk = 16'hFFFF;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (n_wbeats - wc0 == 3) break;
    end
    check("rst_beat_reached", 256'(n_wbeats - wc0), 256'd3);
    i_nrst = 1'b0;
    code = 2'b00;
    #1 check_outputs_zero("midrst");
    repeat (2) @(posedge clk);
    #3 i_nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("post_rst_imported", imported, 256'd0);
    check("post_rst_rpm_cnt", 256'(n_rpm - rpm0), 256'd0);
    for (int k = 0; k < 8; k++) rd_beats[k] = $urandom;
    imp0 = n_imp;
    run_op(2'b01, 15'h0321, 15'h0000, 256'h0, 16'h0, 0, lat);
    check("post_rst_imp_cnt", 256'(n_imp - imp0), 256'd1);
    check("post_rst_latency", 256'(lat), 256'd11);

`ifdef GPU_BGMOVER_PERF_EN
    @(posedge clk);
    #1 i_nrst = 1'b0;
    #4 i_nrst = 1'b1;
    run_op(2'b10, 15'h0010, 15'h0020, rnd_blk, 16'h00FF, 0, lat);
    run_op(2'b10, 15'h0011, 15'h0021, rnd_blk, 16'h0000, 0, lat);
    run_op(2'b10, 15'h0012, 15'h0022, rnd_blk, 16'hF000, 0, lat);
    check("perf_save", 256'(perf_save), 256'd2);
    check("perf_load", 256'(perf_load), 256'd3);
    check("perf_skip", 256'(perf_skip), 256'd1);
`endif

    repeat (3) @(posedge clk);
    check("left_cmds", 256'(exp_cmd_q.size()), 256'd0);
    check("left_beats", 256'(exp_beat_q.size()), 256'd0);
    check("left_imports", 256'(exp_imp_q.size()), 256'd0);
    check("spike_vs_rpm", 256'(n_spike), 256'(n_rpm));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
